// File: rtl/ks_loader32.sv
// Key-schedule front end: streams a key in 32-bit words, runs the DryGASCON
// schedule with a timeout, re-checks X-word distinctness and hands C/X downstream.
module ks_loader32 #(
    parameter int unsigned MINWIDTH_K = 128,
    parameter int unsigned KWIDTHMAX  = 192,
    parameter int unsigned CWIDTH     = 128,
    parameter int unsigned XWIDTH     = 64,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           kw_in,
    input  logic [31:0]          key_word,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [KWIDTHMAX-1:0] ks_k,
    output logic [1:0]           ks_kWidth,
    output logic                 ks_reset,
    input  logic [CWIDTH-1:0]    ks_cout,
    input  logic [XWIDTH-1:0]    ks_xout,
    input  logic                 ks_done,
    output logic [CWIDTH-1:0]    c_out,
    output logic [XWIDTH-1:0]    x_out,
    output logic                 neq_ok,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err
);
    localparam int unsigned XWORDS = XWIDTH / 32;
    localparam int unsigned KWORDS = KWIDTHMAX / 32;
    localparam int unsigned NW     = $clog2(KWORDS + 1);
    localparam int unsigned IW     = (XWORDS > 1) ? $clog2(XWORDS) : 1;
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);

    localparam logic [NW-1:0] LAST_MIN  = NW'(MINWIDTH_K / 32 - 1);
    localparam logic [NW-1:0] LAST_FAST = NW'((MINWIDTH_K + XWIDTH) / 32 - 1);
    localparam logic [NW-1:0] LAST_FULL = NW'((CWIDTH + XWIDTH) / 32 - 1);
    localparam logic [IW-1:0] X_LAST    = IW'(XWORDS - 1);
    localparam logic [IW-1:0] A_LAST    = IW'((XWORDS > 1) ? XWORDS - 2 : 0);
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CHECK,
        S_OUT
    } state_t;

    state_t        state;
    logic [NW-1:0] n;
    logic [NW-1:0] n_last;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] a;
    logic [IW-1:0] b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            neq_ok    <= 1'b0;
            c_out     <= '0;
            x_out     <= '0;
            ks_k      <= '0;
            ks_kWidth <= '0;
            ks_reset  <= 1'b1;
            n         <= '0;
            n_last    <= '0;
            tcnt      <= '0;
            a         <= '0;
            b         <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (kw_in == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            ks_kWidth <= kw_in;
                            ks_k      <= '0;
                            n         <= '0;
                            case (kw_in)
                                2'd0:    n_last <= LAST_MIN;
                                2'd1:    n_last <= LAST_FAST;
                                default: n_last <= LAST_FULL;
                            endcase
                            key_ready <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (key_valid && key_ready) begin
                        for (int unsigned i = 0; i < KWORDS; i++) begin
                            if (n == NW'(i)) ks_k[i*32 +: 32] <= key_word;
                        end
                        n <= n + NW'(1);
                        if (n == n_last) begin
                            key_ready <= 1'b0;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    ks_reset <= 1'b0;
                    tcnt     <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it beats a coincident timeout
                    if (ks_done) begin
                        c_out    <= ks_cout;
                        x_out    <= ks_xout;
                        neq_ok   <= 1'b1;
                        a        <= '0;
                        b        <= IW'(1);
                        ks_reset <= 1'b1;
                        if (XWORDS > 1) begin
                            state <= S_CHECK;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= S_OUT;
                        end
                    end else if (tcnt == T_LAST) begin
                        err      <= 1'b1;
                        ks_reset <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (x_out[a*32 +: 32] == x_out[b*32 +: 32]) neq_ok <= 1'b0;
                    if (a == A_LAST && b == X_LAST) begin
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (b == X_LAST) begin
                        a <= a + IW'(1);
                        b <= a + IW'(1) + IW'(1);
                    end else begin
                        b <= b + IW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ks_loader32.sv
// Scoreboard bench for ks_loader32: driver pushes expected results, a monitor
// pops them on each output handshake or err pulse; a small schedule model drives done.
`timescale 1ns/1ps
module tb_ks_loader32;
    localparam int unsigned TMO = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   kw_in = 2'd0;
    logic [31:0]  key_word = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [191:0] ks_k;
    logic [1:0]   ks_kWidth;
    logic         ks_reset;
    logic [127:0] ks_cout = '0;
    logic [63:0]  ks_xout = '0;
    logic         ks_done;
    logic [127:0] c_out;
    logic [63:0]  x_out;
    logic         neq_ok;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         err;

    ks_loader32 #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .kw_in(kw_in),
        .key_word(key_word), .key_valid(key_valid), .key_ready(key_ready),
        .ks_k(ks_k), .ks_kWidth(ks_kWidth), .ks_reset(ks_reset),
        .ks_cout(ks_cout), .ks_xout(ks_xout), .ks_done(ks_done),
        .c_out(c_out), .x_out(x_out), .neq_ok(neq_ok),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Schedule model: done rises in the dly-th cycle after its reset is released (dly=0: never).
    int unsigned dly = 0;
    int unsigned wcnt = 0;
    always @(posedge clk) wcnt <= ks_reset ? 0 : wcnt + 1;
    assign ks_done = (dly != 0) && !ks_reset && (wcnt + 1 >= dly);

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    typedef struct {
        bit           is_err;
        logic [191:0] k;
        logic [1:0]   kw;
        logic [127:0] c;
        logic [63:0]  x;
        bit           neq;
        int           exp_cyc;
        int           waits;
        int           hold;
    } exp_t;

    exp_t q[$];

    function automatic bit distinct(input logic [63:0] x);
        for (int i = 0; i < 2; i++)
            for (int j = i + 1; j < 2; j++)
                if (x[i*32 +: 32] == x[j*32 +: 32]) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor
    exp_t         me;
    int           vcnt = 0;
    int           wcyc = 0;
    bit           stab_ok = 1'b1;
    logic [127:0] hc;
    logic [63:0]  hx;
    logic         hn;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            vcnt = 0;
            wcyc = 0;
            out_ready = 1'b0;
        end else begin
            if (!ks_reset) wcyc++;
            if (err) begin
                if (q.size() == 0) begin
                    fail("err_unexpected");
                end else begin
                    me = q.pop_front();
                    chk("err_expected", err, me.is_err);
                    chk("err_wait_cycles", wcyc, me.waits);
                    chk("err_busy", busy, 1'b0);
                    chk("err_ks_reset", ks_reset, 1'b1);
                end
                wcyc = 0;
            end
            if (out_valid) begin
                vcnt++;
                if (q.size() == 0 || q[0].is_err) begin
                    fail("valid_unexpected");
                    if (q.size() != 0) me = q.pop_front();
                    out_ready = 1'b1;
                    vcnt = 0;
                end else begin
                    if (vcnt == 1) begin
                        chk("latency", cyc, q[0].exp_cyc);
                        chk("wait_cycles", wcyc, q[0].waits);
                        hc = c_out;
                        hx = x_out;
                        hn = neq_ok;
                        stab_ok = 1'b1;
                    end else if (c_out !== hc || x_out !== hx || neq_ok !== hn || busy !== 1'b1) begin
                        stab_ok = 1'b0;
                    end
                    out_ready = (vcnt > q[0].hold);
                    if (out_ready) begin
                        me = q.pop_front();
                        chk("c_out", c_out, me.c);
                        chk("x_out", x_out, me.x);
                        chk("neq_ok", neq_ok, me.neq);
                        chk("ks_k", ks_k, me.k);
                        chk("ks_kWidth", ks_kWidth, me.kw);
                        chk("ks_reset_out", ks_reset, 1'b1);
                        chk("stable_while_stalled", stab_ok, 1'b1);
                        vcnt = 0;
                        wcyc = 0;
                    end
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    // Driver
    logic [31:0] kwords[6];

    task automatic check_reset_vals(input string tag);
        chk({tag, "_key_ready"}, key_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_neq_ok"}, neq_ok, 1'b0);
        chk({tag, "_c_out"}, c_out, '0);
        chk({tag, "_x_out"}, x_out, '0);
        chk({tag, "_ks_k"}, ks_k, '0);
        chk({tag, "_ks_kWidth"}, ks_kWidth, 2'd0);
        chk({tag, "_ks_reset"}, ks_reset, 1'b1);
    endtask

    task automatic do_start(input logic [1:0] kw);
        @(negedge clk);
        start = 1'b1;
        kw_in = kw;
        @(negedge clk);
        start = 1'b0;
        kw_in = 2'($urandom);
    endtask

    task automatic load(input int n, input bit toggle, output int t);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        t = 0;
        while (i < n && guard < 100) begin
            if (toggle && ph) begin
                key_valid = 1'b0;
                key_word = $urandom;
            end else begin
                key_valid = 1'b1;
                key_word = kwords[i];
            end
            ph = !ph;
            if (key_valid && key_ready) begin
                i++;
                t = cyc;
            end
            @(negedge clk);
            guard++;
        end
        key_valid = 1'b0;
        if (i < n) fail("load_timeout");
        chk("key_ready_drop", key_ready, 1'b0);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((q.size() != 0 || busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) fail("idle_timeout");
        @(negedge clk);
    endtask

    task automatic txn(input logic [1:0] kw, input int d, input logic [63:0] xv,
                       input bit toggle, input int hold, input bit seq);
        exp_t e;
        int n;
        int t;
        n = (kw == 2'd0) ? 4 : 6;
        dly = d;
        ks_cout = {$urandom, $urandom, $urandom, $urandom};
        ks_xout = xv;
        e.k = '0;
        for (int i = 0; i < n; i++) begin
            kwords[i] = seq ? 32'(i + 1) : $urandom;
            e.k[i*32 +: 32] = kwords[i];
        end
        e.is_err = (d == 0) || (d > int'(TMO));
        e.kw = kw;
        e.c = ks_cout;
        e.x = xv;
        e.neq = distinct(xv);
        e.waits = e.is_err ? int'(TMO) : d;
        e.hold = hold;
        do_start(kw);
        load(n, toggle, t);
        e.exp_cyc = t + 3 + d;
        q.push_back(e);
        wait_idle();
    endtask

    function automatic logic [63:0] rand_x();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 2) == 0) return {w, w};
        return {$urandom, w};
    endfunction

    initial begin
        exp_t e;
        int t;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        txn(2'd0, 5, 64'h11111111_22222222, 1'b0, 0, 1'b1);
        txn(2'd1, 3, rand_x(), 1'b1, 0, 1'b0);
        txn(2'd2, 4, 64'hDEADBEEF_DEADBEEF, 1'b0, 0, 1'b0);

        e.is_err = 1'b1;
        e.waits = 0;
        q.push_back(e);
        do_start(2'd3);
        chk("illegal_busy", busy, 1'b0);
        wait_idle();

        txn(2'd0, 0, rand_x(), 1'b0, 0, 1'b0);
        txn(2'd1, int'(TMO), rand_x(), 1'b0, 0, 1'b0);
        txn(2'd2, int'(TMO) + 1, rand_x(), 1'b0, 0, 1'b0);
        txn(2'd0, 1, rand_x(), 1'b0, 0, 1'b0);

        dly = 0;
        for (int i = 0; i < 4; i++) kwords[i] = $urandom;
        do_start(2'd0);
        load(4, 1'b0, t);
        repeat (3) @(negedge clk);
        chk("mid_wait_ks_reset", ks_reset, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        repeat (int'(TMO) + 4) @(negedge clk);

        txn(2'd2, 6, rand_x(), 1'b0, 10, 1'b0);

        for (int i = 0; i < 20; i++) begin
            txn(2'($urandom_range(0, 2)), $urandom_range(0, TMO + 2), rand_x(),
                1'($urandom), $urandom_range(0, 3), 1'b0);
        end

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
